// File: rtl/tl_txn_tracker.sv
// tl_txn_tracker: passive TileLink-UL A/D tracker reporting latency, GET/PUT counts and protocol errors.
// Optional build macro TL_TRACK_ADDR_EN adds per-source address capture reported on done_addr.
module tl_txn_tracker #(
    parameter int SOURCE_BITS    = 2,
    parameter int ADDR_BITS      = 32,
    parameter int LAT_BITS       = 8,
    parameter int CNT_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic [SOURCE_BITS:0]   outstanding_count,
    output logic                   done_valid,
    output logic [SOURCE_BITS-1:0] done_source,
    output logic [LAT_BITS-1:0]    done_latency,
    output logic [ADDR_BITS-1:0]   done_addr,
    output logic [CNT_BITS-1:0]    get_count,
    output logic [CNT_BITS-1:0]    put_count,
    output logic                   err_valid,
    output logic [2:0]             err_code,
    output logic [SOURCE_BITS-1:0] err_source,
    output logic [4:0]             err_sticky
);
    localparam int NUM_SOURCES = 2 ** SOURCE_BITS;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] D_ACK         = 3'd0;
    localparam logic [2:0] D_ACK_DATA    = 3'd1;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_DUP      = 3'd1;
    localparam logic [2:0] ERR_UNEXP    = 3'd2;
    localparam logic [2:0] ERR_MISMATCH = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd5;

    // Timeouts beyond the age counter range can never be reached, so treat them as disabled.
    localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES > 0) && (TIMEOUT_CYCLES <= 2 ** LAT_BITS);
    localparam logic [LAT_BITS-1:0] TIMEOUT_AGE = LAT_BITS'(TIMEOUT_CYCLES - 1);

    function automatic logic [LAT_BITS-1:0] sat_inc(input logic [LAT_BITS-1:0] v);
        if (v == {LAT_BITS{1'b1}}) begin
            return v;
        end else begin
            return v + LAT_BITS'(1);
        end
    endfunction

    function automatic logic age_expired(input logic [LAT_BITS-1:0] v);
        return TIMEOUT_ON ? (v == TIMEOUT_AGE) : 1'b0;
    endfunction

    logic [NUM_SOURCES-1:0] valid_r, is_get_r, timed_out_r;
    logic [LAT_BITS-1:0]    age_r [NUM_SOURCES];

    logic [NUM_SOURCES-1:0] valid_nxt_s, is_get_nxt_s, timed_out_nxt_s, timeout_vec_s;
    logic [LAT_BITS-1:0]    age_nxt_s [NUM_SOURCES];

    logic                   a_fire_s, d_fire_s, a_legal_s, a_alloc_s, a_illegal_s;
    logic                   d_hit_s, d_unexp_s, d_mismatch_s, a_dup_s, timeout_any_s;
    logic [2:0]             d_exp_op_s;
    logic [SOURCE_BITS-1:0] timeout_src_s, err_src_s;
    logic [2:0]             err_code_s;
    logic [4:0]             err_vec_s;
    logic [SOURCE_BITS:0]   outstanding_s;

    assign a_fire_s     = a_valid & a_ready;
    assign d_fire_s     = d_valid & d_ready;
    assign a_alloc_s    = a_fire_s & a_legal_s;
    assign a_illegal_s  = a_fire_s & ~a_legal_s;
    assign d_hit_s      = d_fire_s & valid_r[d_source];
    assign d_unexp_s    = d_fire_s & ~valid_r[d_source];
    assign d_exp_op_s   = is_get_r[d_source] ? D_ACK_DATA : D_ACK;
    assign d_mismatch_s = d_hit_s & (d_opcode != d_exp_op_s);
    // A response retiring the same source in this cycle frees the slot, so re-use is legal.
    assign a_dup_s      = a_alloc_s & valid_r[a_source] & ~(d_fire_s & (d_source == a_source));
    assign timeout_any_s = |timeout_vec_s;

    // Decode legal A-channel opcodes.
    always_comb begin
        case (a_opcode)
            A_PUT_FULL, A_PUT_PARTIAL, A_GET: a_legal_s = 1'b1;
            default:                          a_legal_s = 1'b0;
        endcase
    end

    // Per-source entry next state: allocate wins over retire, otherwise age and check timeout.
    always_comb begin
        valid_nxt_s     = valid_r;
        is_get_nxt_s    = is_get_r;
        timed_out_nxt_s = timed_out_r;
        timeout_vec_s   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            age_nxt_s[i] = age_r[i];
            if (a_alloc_s && (a_source == SOURCE_BITS'(i))) begin
                valid_nxt_s[i]     = 1'b1;
                is_get_nxt_s[i]    = (a_opcode == A_GET);
                age_nxt_s[i]       = '0;
                timed_out_nxt_s[i] = 1'b0;
            end else if (d_hit_s && (d_source == SOURCE_BITS'(i))) begin
                valid_nxt_s[i] = 1'b0;
            end else if (valid_r[i]) begin
                age_nxt_s[i] = sat_inc(age_r[i]);
                if (age_expired(age_r[i]) && !timed_out_r[i]) begin
                    timeout_vec_s[i]   = 1'b1;
                    timed_out_nxt_s[i] = 1'b1;
                end else begin
                    timed_out_nxt_s[i] = timed_out_r[i];
                end
            end else begin
                valid_nxt_s[i] = 1'b0;
            end
        end
    end

    // Lowest-indexed timed-out source wins a TIMEOUT report.
    always_comb begin
        timeout_src_s = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (timeout_vec_s[i]) begin
                timeout_src_s = SOURCE_BITS'(i);
            end else begin
                timeout_src_s = timeout_src_s;
            end
        end
    end

    // Error priority: lowest code is reported, all raised codes go to the sticky vector.
    always_comb begin
        err_vec_s  = {a_illegal_s, timeout_any_s, d_mismatch_s, d_unexp_s, a_dup_s};
        err_code_s = ERR_NONE;
        err_src_s  = '0;
        if (a_dup_s) begin
            err_code_s = ERR_DUP;
            err_src_s  = a_source;
        end else if (d_unexp_s) begin
            err_code_s = ERR_UNEXP;
            err_src_s  = d_source;
        end else if (d_mismatch_s) begin
            err_code_s = ERR_MISMATCH;
            err_src_s  = d_source;
        end else if (timeout_any_s) begin
            err_code_s = ERR_TIMEOUT;
            err_src_s  = timeout_src_s;
        end else if (a_illegal_s) begin
            err_code_s = ERR_ILLEGAL;
            err_src_s  = a_source;
        end else begin
            err_code_s = ERR_NONE;
            err_src_s  = '0;
        end
    end

    // Population count of entries after this edge's updates.
    always_comb begin
        outstanding_s = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            outstanding_s = outstanding_s + (SOURCE_BITS + 1)'(valid_nxt_s[i]);
        end
    end

    // Entry state, counters and registered report outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r           <= '0;
            is_get_r          <= '0;
            timed_out_r       <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                age_r[i] <= '0;
            end
            outstanding_count <= '0;
            done_valid        <= 1'b0;
            done_source       <= '0;
            done_latency      <= '0;
            get_count         <= '0;
            put_count         <= '0;
            err_valid         <= 1'b0;
            err_code          <= ERR_NONE;
            err_source        <= '0;
            err_sticky        <= 5'd0;
        end else begin
            valid_r           <= valid_nxt_s;
            is_get_r          <= is_get_nxt_s;
            timed_out_r       <= timed_out_nxt_s;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                age_r[i] <= age_nxt_s[i];
            end
            outstanding_count <= outstanding_s;
            done_valid        <= d_hit_s;
            if (d_hit_s) begin
                done_source  <= d_source;
                done_latency <= sat_inc(age_r[d_source]);
            end
            if (a_alloc_s) begin
                if (a_opcode == A_GET) begin
                    get_count <= get_count + CNT_BITS'(1);
                end else begin
                    put_count <= put_count + CNT_BITS'(1);
                end
            end
            err_valid  <= |err_vec_s;
            err_code   <= err_code_s;
            err_source <= err_src_s;
            err_sticky <= err_sticky | err_vec_s;
        end
    end

`ifdef TL_TRACK_ADDR_EN
    logic [ADDR_BITS-1:0] addr_r [NUM_SOURCES];

    // Address capture on allocation; the retiring entry's old address is read before overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                addr_r[i] <= '0;
            end
            done_addr <= '0;
        end else begin
            if (a_alloc_s) begin
                addr_r[a_source] <= a_address;
            end
            if (d_hit_s) begin
                done_addr <= addr_r[d_source];
            end
        end
    end
`else
    logic unused_addr_s;
    assign unused_addr_s = ^a_address;
    assign done_addr     = {ADDR_BITS{1'b0}};
`endif

endmodule
